adder_checker: RTL
==================

Name: adder_checker

Overview:
- Response-side counterpart to the adder stimulus sequence: samples the adder's inputs and output on a strobe and checks c == (a + b) mod 2^WIDTH.
- Counts samples and mismatches, captures the first failing vector, and reports pass/fail once EXPECT_N samples are checked.
- Sits beside the adder unit in synthesizable self-test builds, so adder checks need no simulator-only bench.

Parameters:
- WIDTH, 4, operand/result width of the adder under check.
- COUNT_W, 8, width of the sample and error counters.
- EXPECT_N, 100, samples per run; legal range 1..2^COUNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a run.
- sample_valid  input  1  a, b and c are valid to sample this cycle.
- a  input  WIDTH  adder operand a.
- b  input  WIDTH  adder operand b.
- c  input  WIDTH  adder result under check.
- busy  output  1  high while in RUN.
- done  output  1  high while in DONE.
- pass  output  1  valid while done; 1 iff err_count == 0.
- sample_count  output  COUNT_W  samples checked in the current run.
- err_count  output  COUNT_W  mismatches in the current run; saturates at all-ones.
- fail_valid  output  1  a mismatch has been captured in this run.
- fail_a  output  WIDTH  operand a of the first mismatch.
- fail_b  output  WIDTH  operand b of the first mismatch.
- fail_c  output  WIDTH  observed c of the first mismatch.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-run):
  - state = IDLE.
  - busy, done, pass, fail_valid = 0.
  - All counters and fail_* registers = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN next cycle; counters and fail_* clear on that edge.
  - sample_valid is ignored.
- RUN:
  - Each clock edge with sample_valid=1 compares c against expected = (a + b) truncated to WIDTH bits. The carry is discarded, so 15+1=0 is correct for WIDTH=4.
  - sample_count increments on that edge.
  - On a mismatch, err_count increments (saturating at all-ones).
  - On the first mismatch only, fail_a/b/c capture the inputs and fail_valid sets. Later mismatches leave the fail_* registers unchanged.
  - The edge that brings sample_count to EXPECT_N moves the FSM to DONE. That sample is checked and counted on the same edge.
  - Latency: counters and fail_* show a sample's effect on the cycle after it is strobed.
  - start is ignored while in RUN.
- DONE:
  - done=1, busy=0, pass = (err_count == 0). All counters and fail_* hold.
  - sample_valid is ignored; sample_count never exceeds EXPECT_N.
  - start=1 -> RUN next cycle with counters and fail_* cleared (restart without reset).
- Simultaneous events:
  - start and sample_valid in IDLE or DONE: only start acts. That sample is not checked.
  - rst overrides everything.
- Outputs are registered. busy and done are decoded from the state register, so they are glitch-free.
- pass is 0 outside DONE.

Test Plan:
- Clean run:
  - Stimulus: reset, start, then 100 strobes with a incrementing from 1 (mod 16), b = a + 2 (mod 16), c = (a + b) mod 16.
  - Required: done=1, pass=1, sample_count=100, err_count=0, fail_valid=0.
- Wrap-around:
  - Stimulus: EXPECT_N=2; samples a=15,b=1,c=0, then a=14,b=3,c=1.
  - Required: pass=1, err_count=0; the discarded carry is not an error.
- Injected faults:
  - Stimulus: clean run except sample 10 (a=10,b=12,c=5 instead of 6) and sample 50 (a=2,b=4,c=7).
  - Required: err_count=2, fail_valid=1, fail_a=10, fail_b=12, fail_c=5, pass=0.
- Strobe gating and ignored inputs:
  - Stimulus: in RUN, hold sample_valid=0 for 20 cycles with wrong c; pulse start mid-run; keep strobing after DONE.
  - Required: no count change during the gap, start has no effect, sample_count stays at EXPECT_N after DONE.
- Async reset mid-run:
  - Stimulus: assert rst between clock edges after 37 samples.
  - Required: busy, done and all counters read 0 before the next clock edge; state is IDLE.
- Restart from DONE:
  - Stimulus: after a failing run, pulse start together with sample_valid.
  - Required: the coincident sample is not counted; counters and fail_* clear; a following clean 100-sample run gives pass=1.

Source files
------------

// File: rtl/adder_checker.sv
// adder_checker
//   Checks an adder's output against its inputs during self-test. On every
//   strobe in RUN it tests c == (a + b) mod 2^WIDTH. It counts the samples and
//   the mismatches, and it keeps the operands and result of the first mismatch.
//   After EXPECT_N samples it moves to DONE and reports pass/fail.
//
// Ports
//   i_clk           rising-edge clock
//   i_rst           asynchronous, active-high reset
//   i_start         single-cycle pulse; starts a run from IDLE or DONE
//   i_sample_valid  i_a/i_b/i_c are valid to sample this cycle
//   i_a, i_b        adder operands
//   i_c             adder result under check
//   o_busy          high while in RUN
//   o_done          high while in DONE
//   o_pass          high in DONE when no mismatch was seen; 0 elsewhere
//   o_sample_count  samples checked in the current run
//   o_err_count     mismatches in the current run; saturates at all-ones
//   o_fail_valid    a mismatch has been captured in this run
//   o_fail_a/b/c    operands and observed result of the first mismatch
//
// State | meaning
//   S_IDLE | waiting for start after reset; strobes ignored
//   S_RUN  | checking strobed samples until EXPECT_N have been counted
//   S_DONE | results held and reported; start begins a fresh run

module adder_checker #(
  parameter int WIDTH    = 4,
  parameter int COUNT_W  = 8,
  parameter int EXPECT_N = 100
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_sample_valid,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [WIDTH-1:0]   i_c,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic [COUNT_W-1:0] o_sample_count,
  output logic [COUNT_W-1:0] o_err_count,
  output logic               o_fail_valid,
  output logic [WIDTH-1:0]   o_fail_a,
  output logic [WIDTH-1:0]   o_fail_b,
  output logic [WIDTH-1:0]   o_fail_c
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [COUNT_W-1:0] LP_EXPECT = COUNT_W'(EXPECT_N);

  state_t             r_state;
  logic [COUNT_W-1:0] r_sample_count;
  logic [COUNT_W-1:0] r_err_count;
  logic               r_fail_valid;
  logic [WIDTH-1:0]   r_fail_a;
  logic [WIDTH-1:0]   r_fail_b;
  logic [WIDTH-1:0]   r_fail_c;

  state_t             w_state_nxt;
  logic [COUNT_W-1:0] w_sample_count_nxt;
  logic [COUNT_W-1:0] w_err_count_nxt;
  logic               w_fail_valid_nxt;
  logic [WIDTH-1:0]   w_fail_a_nxt;
  logic [WIDTH-1:0]   w_fail_b_nxt;
  logic [WIDTH-1:0]   w_fail_c_nxt;

  logic [WIDTH-1:0]   w_expected;
  logic               w_mismatch;

  // The sum is sized to WIDTH, so the carry out is dropped. This matches
  // an adder whose result is WIDTH bits wide.
  assign w_expected = i_a + i_b;
  assign w_mismatch = (i_c != w_expected);

  always_comb begin
    w_state_nxt        = r_state;
    w_sample_count_nxt = r_sample_count;
    w_err_count_nxt    = r_err_count;
    w_fail_valid_nxt   = r_fail_valid;
    w_fail_a_nxt       = r_fail_a;
    w_fail_b_nxt       = r_fail_b;
    w_fail_c_nxt       = r_fail_c;

    case (r_state)
      S_IDLE, S_DONE: begin
        // A strobe that arrives with start is dropped. Only start acts here.
        if (i_start) begin
          w_state_nxt        = S_RUN;
          w_sample_count_nxt = '0;
          w_err_count_nxt    = '0;
          w_fail_valid_nxt   = 1'b0;
          w_fail_a_nxt       = '0;
          w_fail_b_nxt       = '0;
          w_fail_c_nxt       = '0;
        end
      end

      S_RUN: begin
        if (i_sample_valid) begin
          w_sample_count_nxt = r_sample_count + 1'b1;
          if (w_mismatch) begin
            if (r_err_count != '1) begin
              w_err_count_nxt = r_err_count + 1'b1;
            end
            // Keep only the first failing vector of the run.
            if (!r_fail_valid) begin
              w_fail_valid_nxt = 1'b1;
              w_fail_a_nxt     = i_a;
              w_fail_b_nxt     = i_b;
              w_fail_c_nxt     = i_c;
            end
          end
          // The last sample is counted on the same edge that leaves RUN.
          if (w_sample_count_nxt == LP_EXPECT) begin
            w_state_nxt = S_DONE;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_sample_count <= '0;
      r_err_count    <= '0;
      r_fail_valid   <= 1'b0;
      r_fail_a       <= '0;
      r_fail_b       <= '0;
      r_fail_c       <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_sample_count <= w_sample_count_nxt;
      r_err_count    <= w_err_count_nxt;
      r_fail_valid   <= w_fail_valid_nxt;
      r_fail_a       <= w_fail_a_nxt;
      r_fail_b       <= w_fail_b_nxt;
      r_fail_c       <= w_fail_c_nxt;
    end
  end

  // Status outputs are decoded from registers only.
  assign o_busy         = (r_state == S_RUN);
  assign o_done         = (r_state == S_DONE);
  assign o_pass         = (r_state == S_DONE) && (r_err_count == '0);
  assign o_sample_count = r_sample_count;
  assign o_err_count    = r_err_count;
  assign o_fail_valid   = r_fail_valid;
  assign o_fail_a       = r_fail_a;
  assign o_fail_b       = r_fail_b;
  assign o_fail_c       = r_fail_c;

endmodule
